// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl
// Turns scanner key events into complete BCD entries. Digits shift in at the
// low end, A deletes the last digit, B clears, F hands the entry to the
// consumer over a valid/ready handshake. A holdoff down-counter masks
// repeated detections of a single press.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | accepting keys into the live buffer
// PENDING | completed entry on entry_bcd/entry_len, waiting for ready
module keypad_entry_ctrl #(
  parameter int MAX_DIGITS     = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int LW             = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic                    key_ack,
  output logic [LW-1:0]           digit_count,
  output logic                    overflow,
  output logic                    entry_valid,
  input  logic                    entry_ready,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [LW-1:0]           entry_len
);

  localparam int BW = 4 * MAX_DIGITS;
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_DIGITS);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   digit_buf, digit_buf_next;
  logic [LW-1:0]   digit_len, digit_len_next;
  logic [HW-1:0]   hcnt, hcnt_next;
  logic            overflow_next;
  logic            key_ack_next;
  logic            entry_valid_next;
  logic [BW-1:0]   entry_bcd_next;
  logic [LW-1:0]   entry_len_next;
  logic            accept;

  // Register every piece of state; outputs come straight from flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      digit_buf   <= '0;
      digit_len   <= '0;
      hcnt        <= '0;
      overflow    <= 1'b0;
      key_ack     <= 1'b0;
      entry_valid <= 1'b0;
      entry_bcd   <= '0;
      entry_len   <= '0;
    end else begin
      state       <= state_next;
      digit_buf   <= digit_buf_next;
      digit_len   <= digit_len_next;
      hcnt        <= hcnt_next;
      overflow    <= overflow_next;
      key_ack     <= key_ack_next;
      entry_valid <= entry_valid_next;
      entry_bcd   <= entry_bcd_next;
      entry_len   <= entry_len_next;
    end
  end

  // Next-state logic: key acceptance, buffer editing and the handshake.
  always_comb begin
    state_next       = state;
    digit_buf_next   = digit_buf;
    digit_len_next   = digit_len;
    overflow_next    = overflow;
    key_ack_next     = 1'b0;
    entry_valid_next = entry_valid;
    entry_bcd_next   = entry_bcd;
    entry_len_next   = entry_len;
    hcnt_next        = (hcnt != '0) ? hcnt - 1'b1 : hcnt;

    // Keys arriving while an entry is pending are dropped, not queued.
    accept = key_valid && (hcnt == '0) && (state == COLLECT);

    case (state)
      COLLECT: begin
        if (accept) begin
          key_ack_next = 1'b1;
          hcnt_next    = HOLD_LOAD;
          case (key_code)
            4'hA: begin
              if (digit_len != '0) begin
                digit_buf_next = digit_buf >> 4;
                digit_len_next = digit_len - 1'b1;
              end
            end
            4'hB: begin
              digit_buf_next = '0;
              digit_len_next = '0;
              overflow_next  = 1'b0;
            end
            4'hC, 4'hD, 4'hE: begin
            end
            4'hF: begin
              entry_bcd_next   = digit_buf;
              entry_len_next   = digit_len;
              entry_valid_next = 1'b1;
              digit_buf_next   = '0;
              digit_len_next   = '0;
              overflow_next    = 1'b0;
              state_next       = PENDING;
            end
            default: begin
              // Codes 0-9: newest digit enters at the low nibble.
              if (digit_len < LEN_MAX) begin
                digit_buf_next = (digit_buf << 4) | BW'(key_code);
                digit_len_next = digit_len + 1'b1;
              end else begin
                overflow_next = 1'b1;
              end
            end
          endcase
        end
      end
      PENDING: begin
        if (entry_ready) begin
          entry_valid_next = 1'b0;
          state_next       = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  assign digit_count = digit_len;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: a queue-based model of the typed digits and a
// cycle-number holdoff window, compared against the DUT after every edge,
// plus directed scenarios with hand-computed expectations.
module tb_keypad_entry_ctrl;
  localparam int MAXD = 4;
  localparam int HOLD = 8;
  localparam int LW   = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              key_valid = 1'b0;
  logic [3:0]        key_code = 4'h0;
  logic              entry_ready = 1'b0;
  logic              key_ack;
  logic [LW-1:0]     digit_count;
  logic              overflow;
  logic              entry_valid;
  logic [4*MAXD-1:0] entry_bcd;
  logic [LW-1:0]     entry_len;

  keypad_entry_ctrl #(.MAX_DIGITS(MAXD), .HOLDOFF_CYCLES(HOLD)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ack(key_ack), .digit_count(digit_count), .overflow(overflow),
    .entry_valid(entry_valid), .entry_ready(entry_ready),
    .entry_bcd(entry_bcd), .entry_len(entry_len)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int ack_count = 0;
  int ev_count = 0;

  // Model state
  int          digits[$];
  bit          m_ovf = 0;
  bit          m_pend = 0;
  bit          m_ack = 0;
  logic [15:0] m_ebcd = '0;
  int          m_elen = 0;
  int          cyc = 0;
  int          m_last = -1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] packed_digits();
    logic [15:0] v = '0;
    foreach (digits[i]) v = (v << 4) | 16'(digits[i]);
    return v;
  endfunction

  // Model update at each edge, then compare half a nanosecond... 1ns later.
  always @(posedge clock) begin
    bit acc;
    if (reset) begin
      digits.delete();
      m_ovf = 0; m_pend = 0; m_ack = 0; m_ebcd = '0; m_elen = 0; m_last = -1000;
    end else begin
      cyc++;
      acc = key_valid && !m_pend && (cyc - m_last > HOLD);
      m_ack = acc;
      if (m_pend && entry_ready) m_pend = 0;
      if (acc) begin
        m_last = cyc;
        if (key_code <= 4'd9) begin
          if (digits.size() < MAXD) digits.push_back(int'(key_code));
          else m_ovf = 1;
        end else if (key_code == 4'hA) begin
          if (digits.size() > 0) void'(digits.pop_back());
        end else if (key_code == 4'hB) begin
          digits.delete();
          m_ovf = 0;
        end else if (key_code == 4'hF) begin
          m_ebcd = packed_digits();
          m_elen = digits.size();
          m_pend = 1;
          digits.delete();
          m_ovf = 0;
        end
      end
    end
    #1;
    if (key_ack === 1'b1) ack_count++;
    if (entry_valid === 1'b1) ev_count++;
    chk("key_ack",     32'(key_ack),     32'(m_ack));
    chk("digit_count", 32'(digit_count), 32'(digits.size()));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("entry_valid", 32'(entry_valid), 32'(m_pend));
    chk("entry_bcd",   32'(entry_bcd),   32'(m_ebcd));
    chk("entry_len",   32'(entry_len),   32'(m_elen));
  end

  task automatic press(input logic [3:0] c, input int gap);
    key_code = c;
    key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  initial begin
    int a0, e0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    entry_ready = 1'b1;
    @(negedge clock);

    // Digits and enter
    a0 = ack_count; e0 = ev_count;
    press(4'h1, 9); press(4'h2, 9); press(4'h3, 9); press(4'hF, 9);
    chk("t1_acks", 32'(ack_count - a0), 32'd4);
    chk("t1_pulses", 32'(ev_count - e0), 32'd1);
    chk("t1_bcd", 32'(entry_bcd), 32'h0123);
    chk("t1_len", 32'(entry_len), 32'd3);
    chk("t1_count", 32'(digit_count), 32'd0);

    // Overflow
    press(4'h9, 9); press(4'h8, 9); press(4'h7, 9); press(4'h6, 9); press(4'h5, 9);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count", 32'(digit_count), 32'd4);
    press(4'hF, 9);
    chk("t2_bcd", 32'(entry_bcd), 32'h9876);
    chk("t2_len", 32'(entry_len), 32'd4);
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // Backspace and clear
    press(4'h4, 9); press(4'h5, 9); press(4'hA, 9); press(4'h6, 9); press(4'hF, 9);
    chk("t3_bcd", 32'(entry_bcd), 32'h0046);
    chk("t3_len", 32'(entry_len), 32'd2);
    a0 = ack_count;
    press(4'hB, 9); press(4'hA, 9);
    chk("t3_empty_acks", 32'(ack_count - a0), 32'd2);
    chk("t3_empty_count", 32'(digit_count), 32'd0);
    press(4'hF, 9);
    chk("t3_empty_len", 32'(entry_len), 32'd0);
    chk("t3_empty_bcd", 32'(entry_bcd), 32'h0000);

    // Holdoff with a held key
    a0 = ack_count;
    key_code = 4'h7; key_valid = 1'b1;
    repeat (20) @(negedge clock);
    key_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("t4_acks", 32'(ack_count - a0), 32'd3);
    chk("t4_count", 32'(digit_count), 32'd3);
    press(4'hB, 9);

    // Backpressure
    entry_ready = 1'b0;
    press(4'h1, 9); press(4'h2, 9); press(4'hF, 0);
    a0 = ack_count;
    for (int i = 0; i < 8; i++) begin
      press(4'h2, 0);
      press(4'h3, 0);
    end
    chk("t5_no_acks", 32'(ack_count - a0), 32'd0);
    chk("t5_valid", 32'(entry_valid), 32'd1);
    chk("t5_bcd", 32'(entry_bcd), 32'h0012);
    chk("t5_len", 32'(entry_len), 32'd2);
    key_code = 4'h4; key_valid = 1'b1; entry_ready = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    chk("t5_drop_valid", 32'(entry_valid), 32'd0);
    chk("t5_drop_ack", 32'(key_ack), 32'd0);
    chk("t5_drop_count", 32'(digit_count), 32'd0);
    chk("t5_bcd_kept", 32'(entry_bcd), 32'h0012);
    press(4'h5, 9);
    chk("t5_next_key", 32'(digit_count), 32'd1);

    // Reset mid-entry and while pending
    press(4'h6, 9);
    chk("t6_pre_count", 32'(digit_count), 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_count", 32'(digit_count), 32'd0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    entry_ready = 1'b0;
    press(4'h7, 9); press(4'hF, 2);
    chk("t6_pending", 32'(entry_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(entry_valid), 32'd0);
    chk("t6_rst_len", 32'(entry_len), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    entry_ready = 1'b1;
    key_code = 4'h3; key_valid = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    chk("t6_first_ack", 32'(key_ack), 32'd1);
    chk("t6_first_count", 32'(digit_count), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      key_valid = ($urandom_range(0, 99) < 30);
      key_code = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
      entry_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clock);
    reset = 1'b0;
    key_valid = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
